// File: rtl/phy_pkg.sv
// Shared PHY definitions used by the phy_tx serializer and the phy_rx aligner.
// Latency: n/a (constants, state encoding and one combinational helper).
// Backpressure: n/a.
package phy_pkg;

  // Line symbols
  localparam logic [7:0] PHY_COM_SYM = 8'hBC;  // comma / alignment symbol
  localparam logic [7:0] PHY_IDL_SYM = 8'h7C;  // idle filler symbol

  // Receive alignment FSM encoding
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKING  = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;

  // A symbol carries payload unless it is one of the two link-control symbols.
  function automatic logic phy_is_payload(input logic [7:0] sym,
                                          input logic [7:0] com,
                                          input logic [7:0] idl);
    return (sym != com) && (sym != idl);
  endfunction

endpackage

// File: rtl/phy_rx_deser8.sv
// 8-bit serial deparallelizer: shift register, symbol bit counter and byte strobe.
// Latency: nxt is combinational on data_in; byte_stb is registered one edge after the 8th bit.
// Backpressure: none; the serial line cannot be stalled, a bit is consumed every clock.
//
// Ports:
//   clk_32f        bit clock
//   default_values synchronous active-high reset
//   data_in        serial bit, MSB first
//   cnt_run        1 = advance the symbol bit counter, 0 = hold it at zero
//   stb_en         1 = emit byte_stb on the last bit of each symbol
//   nxt            shift register contents including the bit being sampled now
//   last_bit       the bit being sampled now completes a symbol
//   byte_stb       one-cycle symbol strobe
module phy_rx_deser8 (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic       data_in,
  input  logic       cnt_run,
  input  logic       stb_en,
  output logic [7:0] nxt,
  output logic       last_bit,
  output logic       byte_stb
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_stb_q, byte_stb_d;

  assign nxt      = {sr_q[6:0], data_in};
  assign last_bit = (bit_cnt_q == 3'd7);
  assign byte_stb = byte_stb_q;

  // The alignment edge happens while hunting, where the counter is held at
  // zero, so symbol phase starts at 0 without a separate clear input.
  always_comb begin
    sr_d       = nxt;
    bit_cnt_d  = cnt_run ? (bit_cnt_q + 3'd1) : 3'd0;
    byte_stb_d = stb_en && last_bit;
  end

  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      sr_q       <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_stb_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_stb_q <= byte_stb_d;
    end
  end

endmodule

// File: rtl/phy_rx_serial_align.sv
// Serial receive aligner: hunts for comma byte alignment, locks after COM_TARGET commas, emits symbols.
// Latency: symbol outputs update one posedge after the edge sampling the symbol's last bit.
// Backpressure: none; output is a strobe every 8 clocks, downstream must accept every byte_stb.
//
// Optional build macro: PHY_RX_ERR_CNT_EN adds err_cnt, a saturating count of
// lock attempts aborted by a non-comma symbol.
//
// Ports:
//   clk_32f        bit clock, all logic on posedge
//   default_values synchronous active-high reset, priority over everything
//   data_in        serial bit, MSB first
//   data_out[7:0]  last completed symbol
//   valid_out      data_out is a payload symbol (not comma/idle)
//   byte_stb       one-cycle pulse when data_out/valid_out update
//   active         link aligned and active (sticky until reset)
//   err_cnt[7:0]   (PHY_RX_ERR_CNT_EN only) aborted lock attempts, saturating
module phy_rx_serial_align
  import phy_pkg::*;
#(
  parameter logic [7:0] COM_SYM    = PHY_COM_SYM,
  parameter logic [7:0] IDL_SYM    = PHY_IDL_SYM,
  parameter int         COM_TARGET = 4
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
`ifdef PHY_RX_ERR_CNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       active
);

  localparam logic [3:0] COM_TGT = 4'(COM_TARGET);

  logic [1:0] state_q, state_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
`endif

  logic [7:0] nxt;
  logic       last_bit;
  logic       is_com;

  phy_rx_deser8 u_deser (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .data_in        (data_in),
    .cnt_run        (state_q != ST_UNLOCKED),
    .stb_en         (state_q == ST_ACTIVE),
    .nxt            (nxt),
    .last_bit       (last_bit),
    .byte_stb       (byte_stb)
  );

  assign is_com = (nxt == COM_SYM);

  always_comb begin
    state_d     = state_q;
    com_cnt_d   = com_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
`ifdef PHY_RX_ERR_CNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    case (state_q)
      ST_UNLOCKED: begin
        // Bit-by-bit hunt: any position where a comma appears becomes the
        // candidate symbol boundary.
        if (is_com) begin
          com_cnt_d = 4'd1;
          state_d   = (COM_TGT == 4'd1) ? ST_ACTIVE : ST_LOCKING;
        end
      end
      ST_LOCKING: begin
        if (last_bit) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_d == COM_TGT) begin
              state_d = ST_ACTIVE;
            end
          end else begin
            // Wrong boundary guess; the hunt restarts on the following bit.
            state_d   = ST_UNLOCKED;
            com_cnt_d = 4'd0;
`ifdef PHY_RX_ERR_CNT_EN
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
`endif
          end
        end
      end
      ST_ACTIVE: begin
        if (last_bit) begin
          data_out_d  = nxt;
          valid_out_d = phy_is_payload(nxt, COM_SYM, IDL_SYM);
        end
      end
      default: begin
        state_d   = ST_UNLOCKED;
        com_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      state_q     <= ST_UNLOCKED;
      com_cnt_q   <= 4'd0;
      data_out_q  <= 8'd0;
      valid_out_q <= 1'b0;
`ifdef PHY_RX_ERR_CNT_EN
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      com_cnt_q   <= com_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
`ifdef PHY_RX_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign active    = (state_q == ST_ACTIVE);
`ifdef PHY_RX_ERR_CNT_EN
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/phy_rx_serial_align.md
Name: phy_rx_serial_align

Overview:
- Receive-side counterpart of the phy_tx serializer.
- Consumes the 1-bit serial line at clk_32f and finds byte alignment on the comma symbol 0xBC.
- Declares link active after 4 consecutive aligned commas, then deparallelizes the stream into 8-bit symbols with a one-cycle strobe every 8 clocks.
- Idle (0x7C) and comma symbols are flagged invalid. Feeds the downstream 1-to-4 lane demux in phy_rx.

Parameters:
- COM_SYM, 8'hBC, comma/alignment symbol.
- IDL_SYM, 8'h7C, idle symbol.
- COM_TARGET, 4, consecutive aligned commas required to go active (range 1..15).

Ports:
- clk_32f  in  1  bit clock; all logic on posedge.
- default_values  in  1  reset: one clock, synchronous, active-high.
- data_in  in  1  serial bit, MSB first, sampled every posedge.
- data_out  out  8  last completed symbol.
- valid_out  out  1  data_out holds a payload symbol; updates only with byte_stb.
- byte_stb  out  1  one-cycle pulse when data_out/valid_out update.
- active  out  1  link aligned and active.

Behaviour:
- Shift register sr[7:0] <= {sr[6:0], data_in} every cycle.
- Define nxt = {sr[6:0], data_in}; all symbol compares use nxt, so decisions are made on the edge that samples the 8th bit.
- Reset (default_values=1 at posedge):
  - sr=0, state=UNLOCKED, bit_cnt=0, com_cnt=0.
  - data_out=0, valid_out=0, byte_stb=0, active=0.
  - Reset has priority over everything, in any state, mid-byte included.
- bit_cnt (3 bits):
  - Increments and wraps 7->0 every cycle in LOCKING and ACTIVE.
  - Forced to 0 on the alignment edge.
  - Held at 0 in UNLOCKED.
- State UNLOCKED: bit-by-bit hunt every cycle. If nxt==COM_SYM: bit_cnt<=0, com_cnt<=1, state<=LOCKING; if COM_TARGET==1, go directly to ACTIVE.
- State LOCKING: acts only on edges where bit_cnt==7.
  - nxt==COM_SYM: com_cnt++. If the new value equals COM_TARGET: state<=ACTIVE, active<=1 on that same edge.
  - nxt!=COM_SYM: state<=UNLOCKED, com_cnt<=0. No rehunt on this edge; hunting resumes next cycle.
- State ACTIVE: on edges where bit_cnt==7:
  - data_out<=nxt, byte_stb<=1.
  - valid_out<=1 unless nxt==COM_SYM or nxt==IDL_SYM (then 0).
  - On all other edges byte_stb<=0; data_out and valid_out hold.
  - ACTIVE is sticky until reset.
- No symbols are output (byte_stb stays 0) in UNLOCKED/LOCKING. The COM that completes locking does not produce a strobe; the first strobe comes 8 cycles later.
- Latency: data_out/byte_stb/valid_out are registered on the edge sampling the symbol's last bit, so they are visible one posedge after it.
- com_cnt: 4 bits, never exceeds COM_TARGET.

Optional Feature:
- Macro: PHY_RX_ERR_CNT_EN.
- When defined:
  - Extra output err_cnt [7:0]: saturating count (stops at 255) of LOCKING->UNLOCKED aborts.
  - Reset to 0.
  - Increments on the abort edge.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package phy_pkg holds: COM_SYM/IDL_SYM constants (shared with phy_tx) and the 2-bit state encoding UNLOCKED=0, LOCKING=1, ACTIVE=2.
- One natural sub-module, phy_rx_deser8: 8-bit shift register plus bit_cnt plus strobe generation. The top keeps the FSM and classification.

Test Plan:
- Reset, then drive 4x 0xBC back-to-back from bit 0 -> active rises on the edge sampling the last bit of the 4th BC; byte_stb stays 0 throughout.
- After lock, send 0x7C then 0xFF -> byte_stb pulses 8 cycles apart; data_out=7C/valid_out=0, then data_out=FF/valid_out=1.
- Prefix 3 random bits, then 4x BC, 0xAA -> alignment found despite the offset; data_out=AA, valid_out=1.
- Send BC, BC, 0x55, then 4x BC -> first attempt aborts (err_cnt=1 with the macro defined), relock succeeds; active=1.
- Pulse default_values mid-byte while ACTIVE -> all outputs 0 next cycle; active stays 0 until 4 new BCs arrive.
- Repeat tx pattern (4x BC, 3x 7C) x2 -> active after the first 4 BC; six 7C strobes and four BC strobes, all valid_out=0.
